// File: rtl/mem_req_pkg.sv
// mem_req_pkg: FSM state type, request record and default widths shared by
// mem_req_queue and its FIFO.
package mem_req_pkg;

    localparam int MEM_REQ_DEPTH  = 4;
    localparam int MEM_REQ_ADDR_W = 24;
    localparam int MEM_REQ_DATA_W = 32;
    localparam int MEM_REQ_LAT    = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mem_req_state_e;

    typedef struct packed {
        logic [MEM_REQ_ADDR_W-1:0] addr;
        logic [MEM_REQ_DATA_W-1:0] data;
        logic                      mode;
    } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: circular request buffer; pointers wrap naturally (DEPTH is a
// power of two), count is one bit wider than the pointers.
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 57
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    // Ready is derived from the pre-edge count, so a full FIFO refuses a push
    // even on an edge where it also pops.
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (!do_push && do_pop) count_d = count_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue: buffers CPU requests and issues them one at a time to the
// cache/RAM subsystem. `MEM_REQ_STATS_EN adds rd_count/wr_count outputs.
module mem_req_queue
    import mem_req_pkg::*;
#(
    parameter int DEPTH   = MEM_REQ_DEPTH,
    parameter int ADDR_W  = MEM_REQ_ADDR_W,
    parameter int DATA_W  = MEM_REQ_DATA_W,
    parameter int MEM_LAT = MEM_REQ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_mode,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_inData,
    output logic              mem_mode,
    input  logic [DATA_W-1:0] mem_outData,
    output logic              busy
`ifdef MEM_REQ_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              mode;
    } req_t;

    mem_req_state_e    state_q, state_d;
    req_t              issue_q, issue_d, fifo_in, fifo_head;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d, rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_mode_q, mem_mode_d, rsp_mode_q, rsp_mode_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              fifo_pop, fifo_full, fifo_empty;

    assign fifo_in = {req_addr, req_data, req_mode};

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (req_valid),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // mem_* are registered: values computed in ISSUE appear from the following
    // edge, so a write holds mem_mode high for exactly one subsystem edge.
    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_mode_d  = 1'b0;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_mode_d  = rsp_mode_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    issue_d  = fifo_head;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr_d = issue_q.addr;
                mem_data_d = issue_q.data;
                mem_mode_d = issue_q.mode;
                cnt_d      = CNT_W'(MEM_LAT - 1);
                state_d    = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = mem_outData;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_addr_d  = issue_q.addr;
                rsp_mode_d  = issue_q.mode;
                rsp_data_d  = issue_q.mode ? issue_q.data : rdata_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_q     <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_mode_q  <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_mode_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_mode_q  <= mem_mode_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_mode_q  <= rsp_mode_d;
        end
    end

    assign req_ready  = !fifo_full;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_mode   = rsp_mode_q;
    assign mem_addr   = mem_addr_q;
    assign mem_inData = mem_data_q;
    assign mem_mode   = mem_mode_q;

`ifdef MEM_REQ_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == RESP) begin
            if (issue_q.mode) begin
                if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
